plic_apb_arbiter: RTL and testbench
===================================

# plic_apb_arbiter

Two-master APB arbiter that shares the single APB slave port of `plic_top` between two requesters, e.g. the hart-side bus bridge and a debug/configuration master. Each master sees a standard APB slave; the arbiter serializes their transfers onto the PLIC port with round-robin fairness. A timeout watchdog completes any transfer the slave never acknowledges with an error. It sits directly in front of `plic_top` in the interrupt subsystem.

## Interface
- `ADDR_W`, 26: APB address width, matching the PLIC slave port.
- `TIMEOUT`, 16: maximum ACCESS cycles before forced error completion; 0 disables the watchdog.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `m0_psel`, `m0_penable`, `m0_pwrite`  in  1 each  master 0 APB controls.
- `m0_paddr`  in  ADDR_W  master 0 address.
- `m0_pwdata`  in  32  master 0 write data.
- `m0_pwstrb`  in  4  master 0 byte strobes.
- `m0_pready`, `m0_pslverr`  out  1 each  master 0 completion and error.
- `m0_prdata`  out  32  master 0 read data.
- `m1_*`: identical port set for master 1.
- `s_psel`, `s_penable`, `s_pwrite`  out  1 each  to PLIC.
- `s_paddr`  out  ADDR_W  to PLIC.
- `s_pwdata`  out  32  to PLIC.
- `s_pwstrb`  out  4  to PLIC.
- `s_pready`, `s_pslverr`  in  1 each  from PLIC.
- `s_prdata`  in  32  from PLIC.

## Operation
- FSM with three states: IDLE, SETUP, ACCESS. Registers: `state`, `grant` (1 bit), `last` (1 bit), `tcnt` (16 bit), and the latched slave address, write, wdata and strobe fields.
- IDLE: request i is `mi_psel`.
  - One request: grant it.
  - Both request: grant `!last`.
  - On grant: latch that master's paddr, pwrite, pwdata, pwstrb into the `s_*` registers; set `grant`; go to SETUP.
  - No request: stay in IDLE.
- SETUP: `s_psel`=1, `s_penable`=0 for exactly one cycle; clear `tcnt`; go to ACCESS.
- ACCESS: `s_psel`=1, `s_penable`=1; `tcnt` increments each cycle.
  - `s_pready`=1: the granted master sees `pready`=1, `prdata`=`s_prdata` and `pslverr`=`s_pslverr` combinationally in that cycle. Set `last`=`grant`; go to IDLE.
  - `TIMEOUT`≠0 and `tcnt`==TIMEOUT-1 with no `s_pready`: complete the granted master with `pready`=1, `pslverr`=1, `prdata`=0. Drop `s_psel`/`s_penable` next cycle; set `last`; go to IDLE.
  - `s_pready` and timeout in the same cycle: the slave response wins (`pslverr`=`s_pslverr`).
- Non-granted master: `pready`=0, `prdata`=0, `pslverr`=0 at all times. Its pending transfer stalls as legal APB wait states.
- Granted master may drop `psel` before completion (protocol violation): the slave transfer still runs to completion or timeout, the response is discarded (no `pready` pulse), and `last` is still updated.
- `s_*` address/data outputs hold their latched values until the next grant.

## Timing
- Reset values: `state`=IDLE, `last`=1 (so master 0 wins the first tie), `grant`=0, `tcnt`=0. All `s_*` outputs 0. All `mi_pready`/`mi_pslverr`/`mi_prdata` 0.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). No completion is issued.
- Minimum latency: master setup in cycle 0, arbiter SETUP in cycle 1, ACCESS in cycle 2. With `s_pready` already high, master `pready` rises in cycle 2, i.e. one wait state versus a direct connection.
- Back-to-back: after completion in cycle n, IDLE occupies cycle n+1 and the next grant is sampled there. Minimum 3 cycles per transfer.
- Completion signals to masters are combinational from `s_pready`/`s_prdata`/`s_pslverr`. Slave-side controls are registered.
- With both masters streaming, grants alternate strictly: m0, m1, m0, …

## Test plan
- Single read: m0 reads 0x000004; PLIC returns 0x00000003 with no wait. Require `s_psel` high in cycles 1–2, `m0_pready` and `m0_prdata`=0x3 in cycle 2, m1 outputs 0 throughout.
- Simultaneous requests after reset: m0 writes 0x1 to 0x002000, m1 writes 0x5 to 0x000008 in the same cycle. Require m0 granted first, then m1; PLIC sees both writes in that order with correct strobes.
- Fairness: both masters issue 4 back-to-back reads. Require the slave sees the order m0,m1,m0,m1,m0,m1,m0,m1, with completions every 3 cycles.
- Timeout: `TIMEOUT`=4 and `s_pready` held 0. Require m1 to get `pready`=1, `pslverr`=1, `prdata`=0 in the 4th ACCESS cycle, and `s_psel` low the next cycle.
- Slave error plus wait states: PLIC inserts 2 wait states and then `s_pslverr`=1. Require `m0_pslverr`=1 on the `pready` cycle and `tcnt` not to trigger.
- Reset during ACCESS: assert `rst_n`=0 mid-transfer. Require all outputs 0 immediately, and a post-reset tie grants m0.

Source files
------------

// File: rtl/plic_apb_arbiter.sv
// Two-master APB arbiter in front of the PLIC slave port.
// Round-robin grant, registered slave-side controls, combinational completion back to the granted master.
module plic_apb_arbiter #(
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [31:0]       m0_pwdata,
  input  logic [3:0]        m0_pwstrb,
  output logic              m0_pready,
  output logic              m0_pslverr,
  output logic [31:0]       m0_prdata,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [31:0]       m1_pwdata,
  input  logic [3:0]        m1_pwstrb,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic [31:0]       m1_prdata,
  output logic              s_psel,
  output logic              s_penable,
  output logic              s_pwrite,
  output logic [ADDR_W-1:0] s_paddr,
  output logic [31:0]       s_pwdata,
  output logic [3:0]        s_pwstrb,
  input  logic              s_pready,
  input  logic              s_pslverr,
  input  logic [31:0]       s_prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        grant;
  logic        last;
  logic [15:0] tcnt;

  logic        pick;
  logic        tout;
  logic        done;
  logic        fire0;
  logic        fire1;
  logic [31:0] rdata;
  logic        rerr;
  logic        penable_unused;

  // Requests are decided on psel alone; penable carries no arbitration information.
  assign penable_unused = m0_penable ^ m1_penable;

  assign pick  = (m0_psel && m1_psel) ? !last : m1_psel;
  assign tout  = (TIMEOUT != 0) && (tcnt == TLAST);
  assign done  = (state == ACCESS) && (s_pready || tout);

  // A master that dropped psel mid-transfer gets no completion pulse.
  assign fire0 = done && !grant && m0_psel;
  assign fire1 = done &&  grant && m1_psel;

  // Slave response takes precedence over a coincident timeout.
  assign rdata = s_pready ? s_prdata  : '0;
  assign rerr  = s_pready ? s_pslverr : 1'b1;

  assign m0_pready  = fire0;
  assign m0_pslverr = fire0 && rerr;
  assign m0_prdata  = fire0 ? rdata : '0;
  assign m1_pready  = fire1;
  assign m1_pslverr = fire1 && rerr;
  assign m1_prdata  = fire1 ? rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last      <= 1'b1;
      tcnt      <= '0;
      s_psel    <= 1'b0;
      s_penable <= 1'b0;
      s_pwrite  <= 1'b0;
      s_paddr   <= '0;
      s_pwdata  <= '0;
      s_pwstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_psel || m1_psel) begin
            grant    <= pick;
            s_pwrite <= pick ? m1_pwrite : m0_pwrite;
            s_paddr  <= pick ? m1_paddr  : m0_paddr;
            s_pwdata <= pick ? m1_pwdata : m0_pwdata;
            s_pwstrb <= pick ? m1_pwstrb : m0_pwstrb;
            s_psel   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          tcnt      <= '0;
          s_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          tcnt <= tcnt + 16'd1;
          if (s_pready || tout) begin
            last      <= grant;
            s_psel    <= 1'b0;
            s_penable <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plic_apb_arbiter.sv
// Directed bench for plic_apb_arbiter: two APB master drivers, a simple PLIC slave model
// and a transfer log with hand-computed expectations.
module tb_plic_apb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel[2], pen[2], pwr[2];
  logic [25:0] paddr[2];
  logic [31:0] pwdata[2];
  logic [3:0]  pwstrb[2];
  logic        pready[2], pslverr[2];
  logic [31:0] prdata[2];
  logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [25:0] s_paddr;
  logic [31:0] s_pwdata, s_prdata;
  logic [3:0]  s_pwstrb;

  // Slave model knobs
  logic        hang = 1'b0;
  logic        err_mode = 1'b0;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_rd = '0;
  int          wait_n = 0;
  int          acc_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int quiet_bad = 0;

  typedef struct {
    logic [25:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          cyc;
  } ent_t;
  ent_t log_q[$];

  plic_apb_arbiter #(.ADDR_W(26), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_psel(psel[0]), .m0_penable(pen[0]), .m0_pwrite(pwr[0]), .m0_paddr(paddr[0]),
    .m0_pwdata(pwdata[0]), .m0_pwstrb(pwstrb[0]),
    .m0_pready(pready[0]), .m0_pslverr(pslverr[0]), .m0_prdata(prdata[0]),
    .m1_psel(psel[1]), .m1_penable(pen[1]), .m1_pwrite(pwr[1]), .m1_paddr(paddr[1]),
    .m1_pwdata(pwdata[1]), .m1_pwstrb(pwstrb[1]),
    .m1_pready(pready[1]), .m1_pslverr(pslverr[1]), .m1_prdata(prdata[1]),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
    .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [25:0] a);
    return {6'b0, a} ^ 32'h5A5A_0000;
  endfunction

  assign s_pready  = !hang && (acc_cnt >= wait_n);
  assign s_pslverr = err_mode;
  assign s_prdata  = use_fixed ? fixed_rd : rd_of(s_paddr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_psel && s_penable && !s_pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(negedge clk) begin
    if (s_psel && s_penable && s_pready)
      log_q.push_back('{addr: s_paddr, wr: s_pwrite, wdata: s_pwdata, strb: s_pwstrb, cyc: cyc});
    for (int i = 0; i < 2; i++)
      if ((pready[i] && !(psel[i] && pen[i])) ||
          (!pready[i] && (pslverr[i] || prdata[i] != 0)))
        quiet_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // APB master transfer; entered and left just after a rising edge.
  task automatic xfer(input int m, input logic wr, input logic [25:0] a, input logic [31:0] d,
                      input logic [3:0] strb, output logic [31:0] rd, output logic err,
                      output int waits);
    psel[m] = 1'b1; pen[m] = 1'b0; pwr[m] = wr; paddr[m] = a; pwdata[m] = d; pwstrb[m] = strb;
    @(posedge clk); #1 pen[m] = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (pready[m]) break;
      waits++;
      if (waits > 40) break;
      @(posedge clk); #1;
    end
    rd = prdata[m];
    err = pslverr[m];
    @(posedge clk); #1 psel[m] = 1'b0; pen[m] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd0[4], rd1[4], rd, rdb;
    logic        e0, e1;
    int          w0, w1;

    for (int i = 0; i < 2; i++) begin
      psel[i] = 0; pen[i] = 0; pwr[i] = 0; paddr[i] = '0; pwdata[i] = '0; pwstrb[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sctl", {s_psel, s_penable, s_pwrite, s_pwstrb}, 0);
    chk("rst_saddr", {s_paddr, s_pwdata}, 0);
    chk("rst_m", {pready[0], pslverr[0], prdata[0], pready[1], pslverr[1]}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Simultaneous writes after reset: m0 first, then m1
    log_q.delete();
    fork
      xfer(0, 1'b1, 26'h002000, 32'h1, 4'hF, rd, e0, w0);
      xfer(1, 1'b1, 26'h000008, 32'h5, 4'h1, rdb, e1, w1);
    join
    chk("sim_n", log_q.size(), 2);
    chk("sim_0", {log_q[0].wr, log_q[0].addr, log_q[0].wdata, log_q[0].strb},
        {1'b1, 26'h002000, 32'h1, 4'hF});
    chk("sim_1", {log_q[1].wr, log_q[1].addr, log_q[1].wdata, log_q[1].strb},
        {1'b1, 26'h000008, 32'h5, 4'h1});
    chk("sim_w", {w0[7:0], w1[7:0]}, {8'd1, 8'd4});

    // Single read, cycle-accurate
    use_fixed = 1'b1; fixed_rd = 32'h3;
    psel[0] = 1; pen[0] = 0; pwr[0] = 0; paddr[0] = 26'h000004;
    @(negedge clk); chk("rd_c0_psel", s_psel, 0);
    @(posedge clk); #1 pen[0] = 1;
    @(negedge clk); chk("rd_c1", {s_psel, s_penable, pready[0], s_paddr}, {3'b100, 26'h4});
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_c2", {s_psel, s_penable, pready[0], pslverr[0], prdata[0]}, {4'b1110, 32'h3});
    chk("rd_c2_m1", {pready[1], pslverr[1], prdata[1]}, 0);
    @(posedge clk); #1 psel[0] = 0; pen[0] = 0;
    @(negedge clk); chk("rd_c3_psel", s_psel, 0);
    use_fixed = 1'b0;
    @(posedge clk); #1;

    // Timeout on m1: 4th ACCESS cycle completes with error
    hang = 1'b1;
    xfer(1, 1'b0, 26'h000030, 32'h0, 4'h0, rd, e1, w1);
    chk("to_resp", {e1, rd}, {1'b1, 32'h0});
    chk("to_waits", w1, 4);
    @(negedge clk); chk("to_drop", {s_psel, s_penable}, 0);
    hang = 1'b0;
    @(posedge clk); #1;

    // Fairness: strict alternation, one completion every 3 cycles
    log_q.delete();
    fork
      for (int k = 0; k < 4; k++) xfer(0, 1'b0, 26'h100 + 26'(4 * k), 32'h0, 4'h0, rd0[k], e0, w0);
      for (int k = 0; k < 4; k++) xfer(1, 1'b0, 26'h200 + 26'(4 * k), 32'h0, 4'h0, rd1[k], e1, w1);
    join
    chk("fair_n", log_q.size(), 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      chk("fair_addr", log_q[k].addr, ((k % 2) == 0 ? 26'h100 : 26'h200) + 26'(4 * (k / 2)));
      if (k > 0) chk("fair_gap", log_q[k].cyc - log_q[k-1].cyc, 3);
    end
    for (int k = 0; k < 4; k++) begin
      chk("fair_rd0", rd0[k], rd_of(26'h100 + 26'(4 * k)));
      chk("fair_rd1", rd1[k], rd_of(26'h200 + 26'(4 * k)));
    end

    // Slave error after 2 wait states, below the timeout
    wait_n = 2; err_mode = 1'b1;
    xfer(0, 1'b0, 26'h000044, 32'h0, 4'h0, rd, e0, w0);
    chk("err_resp", {e0, rd}, {1'b1, rd_of(26'h44)});
    chk("err_waits", w0, 3);
    wait_n = 0; err_mode = 1'b0;

    // Reset during ACCESS (last currently favours m1)
    hang = 1'b1;
    psel[1] = 1; pen[1] = 0; pwr[1] = 1; paddr[1] = 26'h123; pwdata[1] = 32'hCAFE; pwstrb[1] = 4'hF;
    @(posedge clk); #1 pen[1] = 1;
    @(posedge clk); #1;
    @(negedge clk); chk("rst_pre", {s_psel, s_penable}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sctl", {s_psel, s_penable, s_pwrite, s_pwstrb}, 0);
    chk("arst_saddr", {s_paddr, s_pwdata}, 0);
    chk("arst_m", {pready[1], pslverr[1], prdata[1]}, 0);
    psel[1] = 0; pen[1] = 0; hang = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    log_q.delete();
    fork
      xfer(0, 1'b0, 26'h310, 32'h0, 4'h0, rd, e0, w0);
      xfer(1, 1'b0, 26'h314, 32'h0, 4'h0, rdb, e1, w1);
    join
    chk("prst_n", log_q.size(), 2);
    chk("prst_first", log_q[0].addr, 26'h310);
    chk("prst_second", log_q[1].addr, 26'h314);

    chk("quiet", quiet_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
